// File: rtl/count_checker.sv
// count_checker: locks onto an incrementing count stream, predicts each next sample, flags and counts slips.
// Optional COUNT_CHECKER_STICKY_EN adds sticky_err_o, held from the first locked mismatch until reset/clear.
module count_checker #(
  parameter int WIDTH       = 8,
  parameter int LOCK_COUNT  = 4,
  parameter int UNLOCK_ERRS = 2,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [WIDTH-1:0] expected_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [7:0]       wrap_cnt_o
`ifdef COUNT_CHECKER_STICKY_EN
  ,
  output logic             sticky_err_o
`endif
);
  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  state_t           r_state, w_next;
  logic [RW-1:0]    r_run;
  logic [BW-1:0]    r_bad;
  logic [WIDTH-1:0] r_exp;
  logic             r_err;
  logic [ERR_W-1:0] r_err_cnt;
  logic [7:0]       r_wrap;
  logic             w_match, w_lock_hit, w_drop;
  logic [RW-1:0]    w_run_inc;
  logic [BW-1:0]    w_bad_inc;
  assign w_match    = cnt_i == r_exp;
  assign w_run_inc  = r_run + 1'b1;
  assign w_bad_inc  = r_bad + 1'b1;
  assign w_lock_hit = w_match && (w_run_inc == RW'(LOCK_COUNT));
  assign w_drop     = !w_match && (w_bad_inc == BW'(UNLOCK_ERRS));
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= SEARCH;
    else r_state <= w_next;
  always_comb begin
    w_next = clear_i ? SEARCH :
             !valid_i ? r_state :
             r_state == SEARCH ? ACQUIRE :
             r_state == ACQUIRE ? (w_lock_hit ? LOCKED : ACQUIRE) :
             (w_drop ? ACQUIRE : LOCKED);
  end
`ifdef COUNT_CHECKER_STICKY_EN
  logic r_sticky;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_sticky <= 1'b0;
    else if (clear_i) r_sticky <= 1'b0;
    else if (valid_i && r_state == LOCKED && !w_match) r_sticky <= 1'b1;
  assign sticky_err_o = r_sticky;
`endif
  // Once locked the prediction freewheels, so a lone corrupted sample costs one error only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run     <= '0;
      r_bad     <= '0;
      r_exp     <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_wrap    <= '0;
    end else if (clear_i) begin
      r_run     <= '0;
      r_bad     <= '0;
      r_exp     <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_wrap    <= '0;
    end else begin
      r_err <= 1'b0;
      if (valid_i) begin
        case (r_state)
          SEARCH: begin
            r_exp <= cnt_i + 1'b1;
            r_run <= '0;
          end
          ACQUIRE: begin
            r_exp <= cnt_i + 1'b1;
            r_run <= w_match ? w_run_inc : '0;
            r_bad <= '0;
          end
          LOCKED: begin
            r_exp <= w_drop ? cnt_i + 1'b1 : r_exp + 1'b1;
            r_run <= '0;
            r_bad <= w_match ? '0 : w_bad_inc;
            r_err <= !w_match;
            if (!w_match && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            if (w_match && cnt_i == '0 && r_wrap != '1) r_wrap <= r_wrap + 1'b1;
          end
          default: r_run <= '0;
        endcase
      end
    end
  end
  always_comb begin
    locked_o   = r_state == LOCKED;
    err_o      = r_err;
    expected_o = r_exp;
    err_cnt_o  = r_err_cnt;
    wrap_cnt_o = r_wrap;
  end
endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: scoreboard bench for count_checker; a reference model queues expected outputs per driven cycle.
module tb_count_checker;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_i = 1'b0;
  logic [7:0]  cnt_i = '0;
  logic        clear_i = 1'b0;
  logic        locked_o, err_o;
  logic [7:0]  expected_o, wrap_cnt_o;
  logic [15:0] err_cnt_o;
  logic        sticky;
`ifdef COUNT_CHECKER_STICKY_EN
  logic sticky_err_o;
  assign sticky = sticky_err_o;
`else
  assign sticky = 1'b0;
`endif
  count_checker dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .cnt_i(cnt_i), .clear_i(clear_i),
    .locked_o(locked_o), .err_o(err_o), .expected_o(expected_o),
    .err_cnt_o(err_cnt_o), .wrap_cnt_o(wrap_cnt_o)
`ifdef COUNT_CHECKER_STICKY_EN
    , .sticky_err_o(sticky_err_o)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {bit lk; bit er; int ex; int ec; int wr; bit st;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_bad = 0, n_errp = 0;
  int m_state, m_run, m_bad, m_exp, m_ecnt, m_wrap;
  bit m_err, m_sticky;
  task automatic chk(input string tag, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask
  task automatic model_clear();
    m_state = 0; m_run = 0; m_bad = 0; m_exp = 0; m_ecnt = 0; m_wrap = 0;
    m_err = 0; m_sticky = 0;
  endtask
  task automatic model(input bit v, input int c, input bit clr);
    if (clr) begin
      model_clear();
      return;
    end
    m_err = 0;
    if (!v) return;
    if (m_state == 0) begin
      m_exp = (c + 1) % 256; m_run = 0; m_state = 1;
    end else if (m_state == 1) begin
      if (c == m_exp) begin
        m_run++;
        if (m_run == 4) begin m_state = 2; m_bad = 0; end
      end else m_run = 0;
      m_exp = (c + 1) % 256;
    end else if (c == m_exp) begin
      m_bad = 0;
      if (c == 0 && m_wrap < 255) m_wrap++;
      m_exp = (m_exp + 1) % 256;
    end else begin
      m_err = 1; m_sticky = 1; m_bad++;
      if (m_ecnt < 65535) m_ecnt++;
      m_exp = (m_exp + 1) % 256;
      if (m_bad == 2) begin m_state = 1; m_run = 0; m_exp = (c + 1) % 256; end
    end
  endtask
  task automatic step(input bit v, input int c, input bit clr);
    exp_t e;
    valid_i = v; cnt_i = 8'(c); clear_i = clr;
    @(posedge clk);
    model(v, c, clr);
    e = '{lk: m_state == 2, er: m_err, ex: m_exp, ec: m_ecnt, wr: m_wrap, st: m_sticky};
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    if (err_o) n_errp++;
    chk("locked", locked_o, e.lk);
    chk("err", err_o, e.er);
    chk("expected", expected_o, e.ex);
    chk("err_cnt", err_cnt_o, e.ec);
    chk("wrap_cnt", wrap_cnt_o, e.wr);
`ifdef COUNT_CHECKER_STICKY_EN
    chk("sticky", sticky, e.st);
`endif
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, locked_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_expected"}, expected_o, 0);
    chk({tag, "_err_cnt"}, err_cnt_o, 0);
    chk({tag, "_wrap"}, wrap_cnt_o, 0);
    chk({tag, "_sticky"}, sticky, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    // clean 0..127 run
    for (int i = 0; i < 128; i++) begin
      step(1, i, 0);
      if (i == 3) chk("lock_pre", locked_o, 0);
      if (i == 4) chk("lock_at5", locked_o, 1);
    end
    chk("clean_exp", expected_o, 128);
    chk("clean_errp", n_errp, 0);
    chk("clean_ecnt", err_cnt_o, 0);
    chk("clean_wrap", wrap_cnt_o, 0);
    // single corrupted sample
    step(0, 0, 1);
    n_errp = 0;
    for (int i = 0; i < 50; i++) step(1, i == 40 ? 8'hAA : i, 0);
    chk("corrupt_errp", n_errp, 1);
    chk("corrupt_ecnt", err_cnt_o, 1);
    chk("corrupt_lock", locked_o, 1);
    chk("corrupt_exp", expected_o, 50);
    // genuine skip 50 -> 60
    step(0, 0, 1);
    n_errp = 0;
    for (int i = 0; i <= 50; i++) step(1, i, 0);
    for (int i = 60; i <= 70; i++) begin
      step(1, i, 0);
      if (i == 60) chk("skip_lock60", locked_o, 1);
      if (i == 61) chk("skip_drop61", locked_o, 0);
      if (i == 64) chk("skip_lock64", locked_o, 0);
      if (i == 65) chk("skip_relock65", locked_o, 1);
    end
    chk("skip_errp", n_errp, 2);
    chk("skip_ecnt", err_cnt_o, 2);
    // rollover with gaps
    step(0, 0, 1);
    n_errp = 0;
    for (int i = 250; i < 266; i++) begin
      step(1, i % 256, 0);
      if (i % 3 == 0) begin
        step(0, 8'h5A, 0);
        chk("gap_err", err_o, 0);
      end
    end
    chk("wrap_cnt1", wrap_cnt_o, 1);
    chk("wrap_errp", n_errp, 0);
    chk("wrap_lock", locked_o, 1);
    // clear beats a coincident mismatching sample
    step(1, 8'h77, 0);
    step(1, 11, 0);
    chk("pre_clear_ecnt", err_cnt_o, 1);
    step(1, 8'h33, 1);
    chk_zero("clear");
    step(1, 100, 0);
    chk("post_clear_seed", expected_o, 101);
    chk("post_clear_lock", locked_o, 0);
    // asynchronous reset between edges
    for (int i = 0; i < 10; i++) step(1, i, 0);
    chk("pre_rst_lock", locked_o, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("async_rst");
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 20; i <= 30; i++) begin
      step(1, i, 0);
      if (i == 23) chk("rst_lock_pre", locked_o, 0);
      if (i == 24) chk("rst_relock", locked_o, 1);
    end
    chk("rst_exp", expected_o, 31);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/count_checker.md
# count_checker

Sequence checker for free-running counter streams. It samples a WIDTH-bit count on qualified cycles, locks onto an incrementing sequence, and then predicts each next value. Mismatches are flagged and counted, and a sustained slip drops lock. It sits on the consuming end of the counter blocks: a counter's output feeds `cnt_i` for in-system and bench self-checking.

## Interface
- `WIDTH`, 8: width of checked count.
- `LOCK_COUNT`, 4: consecutive correct increments after the seed sample needed to lock (≥1).
- `UNLOCK_ERRS`, 2: consecutive mismatches while locked that drop lock (≥1).
- `ERR_W`, 16: width of error counter.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  `cnt_i` is a sample this cycle.
- `cnt_i`  in  WIDTH  observed count.
- `clear_i`  in  1  synchronous clear to search state.
- `locked_o`  out  1  checker is locked.
- `err_o`  out  1  one-cycle mismatch pulse.
- `expected_o`  out  WIDTH  predicted next sample value.
- `err_cnt_o`  out  ERR_W  mismatches while locked; saturates at 2^ERR_W−1.
- `wrap_cnt_o`  out  8  locked, matching samples equal to 0 (rollovers); saturates at 255.

## Operation
- States:
  - SEARCH (reset state)
  - ACQUIRE (internal `run` counter)
  - LOCKED (internal `bad` counter)
- All arithmetic is mod 2^WIDTH.
- Only cycles with `valid_i`=1 advance state. With `valid_i`=0, everything holds except `err_o`, which returns to 0.
- SEARCH, valid sample: `expected_o`←`cnt_i`+1, `run`←0, go to ACQUIRE.
- ACQUIRE, valid sample:
  - `cnt_i`==`expected_o`: `run`+1. If `run`+1==LOCK_COUNT, go to LOCKED with `bad`←0; otherwise stay.
  - Mismatch: `run`←0 and stay (reseed).
  - In both cases `expected_o`←`cnt_i`+1.
  - Mismatches in ACQUIRE are not counted and do not pulse `err_o`.
- LOCKED, valid sample:
  - `expected_o`←`expected_o`+1 (freewheel; it does not resync to the input).
  - Match: `bad`←0. If `cnt_i`==0, `wrap_cnt_o` increments.
  - Mismatch: `err_o`←1, `err_cnt_o` increments, `bad`+1. If `bad`+1==UNLOCK_ERRS, go to ACQUIRE with `run`←0 and `expected_o`←`cnt_i`+1.
- A single corrupted sample therefore costs exactly one error. A genuine skip costs UNLOCK_ERRS errors and then relocks.
- `clear_i`=1 has priority over `valid_i` in the same cycle:
  - state←SEARCH;
  - all outputs and internal counters←0;
  - the coincident sample is discarded.
- Both counters saturate and never wrap.

## Timing
- Reset (`reset`=0, asynchronous): `locked_o`=0, `err_o`=0, `expected_o`=0, `err_cnt_o`=0, `wrap_cnt_o`=0, state SEARCH. Release is taken synchronously on the next edge.
- All outputs are registered. Each reflects the valid sample captured at edge N from just after edge N, i.e. 1-cycle latency.
- `locked_o` rises after the edge that captures sample LOCK_COUNT+1 of a clean run (seed plus LOCK_COUNT matches). With defaults and back-to-back valids this is the 5th sample.
- `locked_o` falls after the edge that captures the UNLOCK_ERRS-th consecutive mismatch. `err_o` is high in that same cycle.
- `err_o` is never high for more than one cycle per mismatching sample. It stays high across consecutive-cycle mismatches.

## Configuration
- `COUNT_CHECKER_STICKY_EN` defined:
  - Adds output `sticky_err_o` (1 bit).
  - It is set on the edge where `err_o` is set, and cleared only by `reset` or `clear_i`. Reset value 0.
- Not defined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Reset held 2 cycles, then a counter 0..127 on `valid_i`=1 every cycle:
  - `locked_o`=1 from the cycle after sample 4;
  - `err_o` never 1;
  - `err_cnt_o`=0, `wrap_cnt_o`=0;
  - `expected_o`=128 at the end.
- Locked stream with sample 40 replaced by 0xAA, followed by 41, 42…:
  - exactly one `err_o` pulse;
  - `err_cnt_o`=1;
  - `locked_o` stays 1;
  - `expected_o` unaffected.
- Locked stream that jumps 50→60 and continues from 60:
  - `err_o` for 60 and 61, `err_cnt_o`=2;
  - `locked_o` drops after 61;
  - relocks after 65 with no further errors.
- Count 250..255,0..9 locked, with gaps in `valid_i`: `wrap_cnt_o`=1, no errors, `err_o` low during gaps.
- `clear_i` asserted together with a valid mismatching sample while locked:
  - next cycle all outputs are 0 and state is SEARCH;
  - no `err_o` pulse;
  - with `COUNT_CHECKER_STICKY_EN`, `sticky_err_o` is also cleared.
- `reset` asserted mid-stream, between clock edges: all outputs 0 immediately, without waiting for a clock edge. After release the checker reacquires from the next samples.
